seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/hex7seg.sv | 13 +
 rtl/seg_scan.sv | 100 ++++++++++
 tb/tb_seg_scan.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: constants shared by the seg_scan display driver and its decoder.
// Holds the active-low hex font ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// all-dark anode/cathode patterns used whenever a digit must stay unlit.
package seg_scan_pkg;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = nibble value; glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment decoder.
// Ports: i_nib  - 4-bit hex value to show
//        o_seg  - active-low cathodes {g,f,e,d,c,b,a}
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_FONT[i_nib];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an 8-digit common-anode hex display.
// Ports: clk_board/rst (async, active-high) clock and reset; data/dp/digit_en
//        per-digit value, decimal point and enable; blank forces all digits dark;
//        an/seg/dp_n are registered active-low anode, cathode and dp drives.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_board,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap_data;
  logic [7:0]    r_snap_dp;
  logic [7:0]    r_snap_en;
  // High only for the first edge after reset, when the snapshot is loaded.
  logic          r_first;

  logic          w_tick;
  logic          w_frame_end;
  logic [31:0]   w_data_eff;
  logic [7:0]    w_dp_eff;
  logic [7:0]    w_en_eff;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_lit;

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd7);

  // On the first edge after reset the snapshot register still holds zero, so
  // the output path looks straight at the inputs being captured. That gives
  // digit 0 of the first frame its full dwell instead of one dark cycle.
  assign w_data_eff = r_first ? data     : r_snap_data;
  assign w_dp_eff   = r_first ? dp       : r_snap_dp;
  assign w_en_eff   = r_first ? digit_en : r_snap_en;

  assign w_nib = w_data_eff[{r_idx, 2'b00} +: 4];
  assign w_lit = w_en_eff[r_idx] & ~blank;

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk_board or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= 3'd0;
      r_snap_data <= 32'h0;
      r_snap_dp   <= 8'h0;
      r_snap_en   <= 8'h0;
      r_first     <= 1'b1;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp_n        <= 1'b1;
    end else begin
      r_first <= 1'b0;

      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // The snapshot only moves at frame boundaries so one frame never mixes
      // two input values.
      if (r_first || w_frame_end) begin
        r_snap_data <= data;
        r_snap_dp   <= dp;
        r_snap_en   <= digit_en;
      end

      if (w_lit) begin
        an   <= ~(8'h01 << r_idx);
        seg  <= w_seg;
        dp_n <= ~w_dp_eff[r_idx];
      end else begin
        an   <= AN_OFF;
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk_board = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  digit_en;
  logic        blank;
  wire  [7:0]  an;
  wire  [6:0]  seg;
  wire         dp_n;

  int checks   = 0;
  int failures = 0;

  seg_scan #(.SCAN_DIV(DIV)) dut (
    .clk_board (clk_board),
    .rst       (rst),
    .data      (data),
    .dp        (dp),
    .digit_en  (digit_en),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n)
  );

  always #5 clk_board = ~clk_board;

  // Reference font, written out independently of the design package.
  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Hand-computed segment sequence for data = 76543210.
  logic [6:0] f0_seg [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: count edges since reset release. Edge n shows digit
  // ((n-1)/DIV) mod 8; the frame contents are the inputs seen on edge 1 and on
  // every edge that ends a frame (n multiple of FRAME), taking effect after it.
  int          m_n = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  m_en = '0;
  logic [7:0]  exp_an = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dpn = 1'b1;

  always @(posedge clk_board or posedge rst) begin
    int d;
    if (rst) begin
      m_n = 0; m_data = '0; m_dp = '0; m_en = '0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dpn = 1'b1;
    end else begin
      m_n++;
      if (m_n == 1) begin
        m_data = data; m_dp = dp; m_en = digit_en;
      end
      d = ((m_n - 1) / DIV) % 8;
      if (!blank && m_en[d]) begin
        exp_an    = 8'hFF;
        exp_an[d] = 1'b0;
        exp_seg   = font[m_data[d*4 +: 4]];
        exp_dpn   = ~m_dp[d];
      end else begin
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dpn = 1'b1;
      end
      if (m_n % FRAME == 0) begin
        m_data = data; m_dp = dp; m_en = digit_en;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_board) begin
    chk("model_an", an, exp_an);
    chk("model_seg", seg, exp_seg);
    chk("model_dpn", dp_n, exp_dpn);
    checks++;
    assert ($onehot0(~an)) else begin
      failures++;
      $display("FAIL an_onehot actual=%0h required=single-zero-or-ff", an);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_board);
  endtask

  initial begin
    logic [7:0] e_an;
    rst = 1'b1; data = 32'h76543210; dp = 8'h00; digit_en = 8'hFF; blank = 1'b0;
    step(3);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dpn", dp_n, 1'b1);

    // First frame: each digit held DIV clocks, starting at digit 0.
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step(1);
      e_an = ~(8'h01 << (k / DIV));
      chk("f0_an", an, e_an);
      chk("f0_seg", seg, f0_seg[k / DIV]);
    end

    // Mid-frame data change while digit 3 is lit (after edge 45).
    step(13);
    data = 32'hFFFFFFFF;
    step(3);  chk("mid_d3_an", an, 8'hF7); chk("mid_d3_seg", seg, 7'h30);
    step(1);  chk("mid_d4_an", an, 8'hEF); chk("mid_d4_seg", seg, 7'h19);
    step(15); chk("mid_d7_an", an, 8'h7F); chk("mid_d7_seg", seg, 7'h78);
    step(1);  chk("new_d0_an", an, 8'hFE); chk("new_d0_seg", seg, 7'h0E);

    // Partial enable with decimal point on digit 0 (visible from edge 97).
    data = 32'h76543210; digit_en = 8'h0F; dp = 8'h01;
    step(32); chk("en_d0_an", an, 8'hFE); chk("en_d0_seg", seg, 7'h40); chk("en_d0_dpn", dp_n, 1'b0);
    step(4);  chk("en_d1_an", an, 8'hFD); chk("en_d1_seg", seg, 7'h79); chk("en_d1_dpn", dp_n, 1'b1);
    step(12); chk("en_d4_an", an, 8'hFF); chk("en_d4_seg", seg, 7'h7F); chk("en_d4_dpn", dp_n, 1'b1);
    digit_en = 8'hFF; dp = 8'h00;
    step(15); chk("en_d7_an", an, 8'hFF); chk("en_d7_seg", seg, 7'h7F);

    // One-clock blank pulse inside digit 0 of the next frame.
    step(2);
    blank = 1'b1;
    step(1);  chk("blank_an", an, 8'hFF); chk("blank_seg", seg, 7'h7F);
    blank = 1'b0;
    step(1);  chk("unblank_an", an, 8'hFE); chk("unblank_seg", seg, 7'h40);
    step(1);  chk("post_blank_an", an, 8'hFD);

    // Asynchronous reset between edges while digit 5 is lit.
    step(17); chk("pre_rst_an", an, 8'hDF); chk("pre_rst_seg", seg, 7'h12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dpn", dp_n, 1'b1);
    step(2);
    rst = 1'b0;
    step(1); chk("restart_an", an, 8'hFE); chk("restart_seg", seg, 7'h40);
    step(3); chk("restart_hold_an", an, 8'hFE);
    step(1); chk("restart_d1_an", an, 8'hFD); chk("restart_d1_seg", seg, 7'h79);

    // Random traffic checked by the model and the one-hot assertion.
    for (int k = 0; k < 1000; k++) begin
      step(1);
      data     = $urandom;
      dp       = 8'($urandom);
      digit_en = 8'($urandom);
      blank    = ($urandom_range(0, 7) == 0);
    end
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
